attn_tile_streamer: RTL and testbench

Host-side initiator that feeds the attention core. It buffers one tile of Q/K/V operands written by the host and launches the core with a start pulse and tile length. It then streams the operands as valid/ready beats, collects the single output word and reports completion, error status and stall statistics back to the host.

---
 rtl/attn_tile_streamer_if.sv | 25 ++
 rtl/attn_tile_streamer.sv | 187 ++++++++++++++++++
 tb/tb_attn_tile_streamer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/attn_tile_streamer_if.sv
// Core-side bus of the attention tile streamer: launch, operand stream, result return.
interface attn_tile_streamer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [15:0]           k_tile;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] k;
  logic [DATA_WIDTH-1:0] v;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output start, k_tile, in_valid, q, k, v, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  start, k_tile, in_valid, q, k, v, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/attn_tile_streamer.sv
// Host-side initiator for the attention core: buffers one Q/K/V tile, launches the
// core, streams operand beats, collects the result and reports status/statistics.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for host_start; host writes land in the buffers
// LAUNCH   | one-cycle core start pulse, first payload is being loaded
// STREAM   | presenting operand beats until beat L-1 is accepted
// WAIT_OUT | waiting for the single result word from the core
module attn_tile_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 6,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_wr_en,
  input  logic [1:0]            host_wr_sel,
  input  logic [ADDR_W-1:0]     host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  input  logic                  host_start,
  input  logic [15:0]           host_len,
  output logic                  host_busy,
  output logic                  host_done,
  output logic                  host_err,
  output logic [DATA_WIDTH-1:0] host_result,
  output logic                  host_result_valid,
  output logic [31:0]           stall_cycles,
  attn_tile_streamer_if.master  core
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_STREAM,
    S_WAIT_OUT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] q_mem [DEPTH];
  logic [DATA_WIDTH-1:0] k_mem [DEPTH];
  logic [DATA_WIDTH-1:0] v_mem [DEPTH];

  logic [DATA_WIDTH-1:0] q_reg, k_reg, v_reg;
  logic [ADDR_W:0]       rd_ptr;
  logic [ADDR_W-1:0]     nxt_idx;
  logic [TW-1:0]         tmr;
  logic [15:0]           k_tile;
  logic [16:0]           eff_len;
  logic                  len_ok;
  logic                  start_ok, start_bad;
  logic                  in_hs, out_hs, last_beat, waiting, tmr_expired;

  // The extra length bit lets a zero length stand for a full DEPTH tile.
  assign eff_len   = (host_len == 16'd0) ? 17'(DEPTH) : {1'b0, host_len};
  assign len_ok    = (eff_len <= 17'(DEPTH));
  assign start_ok  = (state == S_IDLE) && host_start && len_ok;
  assign start_bad = (state == S_IDLE) && host_start && !len_ok;

  assign in_hs       = (state == S_STREAM) && core.in_ready;
  assign out_hs      = (state == S_WAIT_OUT) && core.out_valid;
  assign last_beat   = in_hs && (16'(rd_ptr) == (k_tile - 16'd1));
  assign waiting     = (state == S_STREAM) || (state == S_WAIT_OUT);
  assign tmr_expired = waiting && !in_hs && !out_hs && (tmr == '0);
  assign nxt_idx     = rd_ptr[ADDR_W-1:0] + IDX_ONE;

  assign core.q      = q_reg;
  assign core.k      = k_reg;
  assign core.v      = v_reg;
  assign core.k_tile = k_tile;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt      = state;
    host_busy      = 1'b1;
    core.start     = 1'b0;
    core.in_valid  = 1'b0;
    core.out_ready = 1'b0;
    case (state)
      S_IDLE: begin
        host_busy = 1'b0;
        if (start_ok) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        core.start = 1'b1;
        state_nxt  = S_STREAM;
      end
      S_STREAM: begin
        core.in_valid = 1'b1;
        if (last_beat)        state_nxt = S_WAIT_OUT;
        else if (tmr_expired) state_nxt = S_IDLE;
      end
      S_WAIT_OUT: begin
        core.out_ready = 1'b1;
        if (out_hs || tmr_expired) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand buffers; only writable while idle so a running stream never sees new data.
  always_ff @(posedge clk) begin
    if (host_wr_en && (state == S_IDLE)) begin
      case (host_wr_sel)
        2'd0:    q_mem[host_wr_addr] <= host_wr_data;
        2'd1:    k_mem[host_wr_addr] <= host_wr_data;
        2'd2:    v_mem[host_wr_addr] <= host_wr_data;
        default: ;
      endcase
    end
  end

  // Run bookkeeping: tile length, read pointer, payload, timer, status and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_tile            <= '0;
      rd_ptr            <= '0;
      tmr               <= '0;
      q_reg             <= '0;
      k_reg             <= '0;
      v_reg             <= '0;
      stall_cycles      <= '0;
      host_done         <= 1'b0;
      host_err          <= 1'b0;
      host_result       <= '0;
      host_result_valid <= 1'b0;
    end else begin
      host_done <= 1'b0;

      if (start_ok) begin
        k_tile            <= eff_len[15:0];
        rd_ptr            <= '0;
        tmr               <= TMR_LOAD;
        stall_cycles      <= '0;
        host_err          <= 1'b0;
        host_result_valid <= 1'b0;
      end

      if (start_bad) host_err <= 1'b1;

      // Payload is loaded a beat ahead so the core sees registered operands only.
      if (state == S_LAUNCH) begin
        q_reg <= q_mem[rd_ptr[ADDR_W-1:0]];
        k_reg <= k_mem[rd_ptr[ADDR_W-1:0]];
        v_reg <= v_mem[rd_ptr[ADDR_W-1:0]];
      end

      if ((state == S_STREAM) && !core.in_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;

      if (in_hs) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        tmr    <= TMR_LOAD;
        q_reg  <= q_mem[nxt_idx];
        k_reg  <= k_mem[nxt_idx];
        v_reg  <= v_mem[nxt_idx];
      end else if (waiting && !out_hs && (tmr != '0)) begin
        tmr <= tmr - 1'b1;
      end

      if (out_hs) begin
        host_result       <= core.out_data;
        host_result_valid <= 1'b1;
        host_done         <= 1'b1;
      end

      if (tmr_expired) begin
        host_err  <= 1'b1;
        host_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_attn_tile_streamer.sv
// Bench for attn_tile_streamer: a run-level model (beat counts, idle counts, queued
// expectations) checked against the DUT every cycle, plus literal checks per scenario.
module tb_attn_tile_streamer;
  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_wr_en = 1'b0;
  logic [1:0]    host_wr_sel = '0;
  logic [AW-1:0] host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_start = 1'b0;
  logic [15:0]   host_len = '0;
  logic          host_busy, host_done, host_err, host_result_valid;
  logic [DW-1:0] host_result;
  logic [31:0]   stall_cycles;

  attn_tile_streamer_if #(.DATA_WIDTH(DW)) core_bus ();

  attn_tile_streamer #(.DATA_WIDTH(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wr_en(host_wr_en), .host_wr_sel(host_wr_sel), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_start(host_start), .host_len(host_len),
    .host_busy(host_busy), .host_done(host_done), .host_err(host_err),
    .host_result(host_result), .host_result_valid(host_result_valid),
    .stall_cycles(stall_cycles), .core(core_bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mq [DEPTH];
  logic [DW-1:0] mk [DEPTH];
  logic [DW-1:0] mv [DEPTH];
  bit            m_active = 0, e_start = 0, e_done = 0, m_err = 0, m_rv = 0;
  bit            e_valid = 0, e_oready = 0;
  int            m_len = 0, m_beats = 0, m_idle = 0;
  logic [31:0]   m_stalls = '0;
  logic [DW-1:0] m_result = '0;
  logic [15:0]   m_kt = '0;

  initial forever begin : model
    bit hs_in, hs_out, launching;
    int len;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 0; e_start = 0; e_done = 0; m_err = 0; m_rv = 0;
      e_valid = 0; e_oready = 0; m_len = 0; m_beats = 0; m_idle = 0;
      m_stalls = '0; m_result = '0; m_kt = '0;
    end else begin
      hs_in     = e_valid && core_bus.in_ready;
      hs_out    = e_oready && core_bus.out_valid;
      launching = e_start;
      e_start   = 0;
      e_done    = 0;
      if (!m_active) begin
        if (host_wr_en) begin
          case (host_wr_sel)
            2'd0: mq[host_wr_addr] = host_wr_data;
            2'd1: mk[host_wr_addr] = host_wr_data;
            2'd2: mv[host_wr_addr] = host_wr_data;
            default: ;
          endcase
        end
        if (host_start) begin
          len = (host_len == 16'd0) ? DEPTH : int'(host_len);
          if (len > DEPTH) m_err = 1;
          else begin
            m_active = 1; e_start = 1; m_len = len; m_kt = 16'(len);
            m_beats = 0; m_idle = 0; m_stalls = '0; m_err = 0; m_rv = 0;
          end
        end
      end else if (!launching) begin
        if (e_valid && !core_bus.in_ready && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
        if (hs_in) begin
          m_beats++;
          m_idle = 0;
        end else if (hs_out) begin
          m_result = core_bus.out_data; m_rv = 1; e_done = 1; m_active = 0;
        end else begin
          m_idle++;
          if (m_idle >= TO) begin m_err = 1; e_done = 1; m_active = 0; end
        end
      end
      e_valid  = m_active && !e_start && (m_beats < m_len);
      e_oready = m_active && !e_start && (m_beats == m_len);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin : compare
    @(negedge clk);
    chk("host_busy", host_busy, m_active);
    chk("host_done", host_done, e_done);
    chk("host_err", host_err, m_err);
    chk("host_result_valid", host_result_valid, m_rv);
    chk("host_result", host_result, m_result);
    chk("stall_cycles", stall_cycles, m_stalls);
    chk("core_start", core_bus.start, e_start);
    chk("core_k_tile", core_bus.k_tile, m_kt);
    chk("core_in_valid", core_bus.in_valid, e_valid);
    chk("core_out_ready", core_bus.out_ready, e_oready);
    if (e_valid) begin
      chk("core_q", core_bus.q, mq[m_beats]);
      chk("core_k", core_bus.k, mk[m_beats]);
      chk("core_v", core_bus.v, mv[m_beats]);
    end
  end

  // ---------------- monitors ----------------
  int            cyc = 0, start_cnt = 0, done_cnt = 0, start_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  logic [DW-1:0] beat_q [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Handshakes are logged half a cycle before the accepting edge.
  initial forever begin
    @(negedge clk);
    if (core_bus.in_valid && core_bus.in_ready) begin
      beat_q.push_back(core_bus.q);
      last_hs_cyc = cyc;
    end
    if (core_bus.start) begin start_cnt++; start_cyc = cyc; end
    if (host_done) begin done_cnt++; done_cyc = cyc; end
  end

  // ---------------- core-side driver ----------------
  int            rdy_mode = 0, resp_delay = 0, vcnt = 0, wcnt = 0;
  bit            noise = 0;
  logic [DW-1:0] resp_data = '0;

  initial begin
    core_bus.in_ready  = 1'b0;
    core_bus.out_valid = 1'b0;
    core_bus.out_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: core_bus.in_ready = 1'b1;
        1: begin
          core_bus.in_ready = vcnt[0];
          if (core_bus.in_valid) vcnt++;
        end
        default: core_bus.in_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (core_bus.out_ready) begin
        wcnt++;
        core_bus.out_valid = (resp_delay >= 0) && (wcnt > resp_delay);
        core_bus.out_data  = resp_data;
      end else begin
        wcnt = 0;
        core_bus.out_valid = noise && ($urandom_range(0, 1) == 1);
        core_bus.out_data  = DW'($urandom);
      end
    end
  end

  // ---------------- host tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hwrite(input int sel, input int addr, input logic [DW-1:0] d);
    host_wr_en = 1'b1; host_wr_sel = 2'(sel); host_wr_addr = AW'(addr); host_wr_data = d;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic start_run(input int len, output int acc);
    host_start = 1'b1; host_len = 16'(len);
    tick();
    acc = cyc;
    host_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (host_busy && n < budget) begin
      tick();
      n++;
    end
    chk({name, " idle within bound"}, host_busy, 0);
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  logic [DW-1:0] wq [8];
  int            acc, nw, ln, sc;

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick();
    chk("reset busy", host_busy, 0);
    chk("reset k_tile", core_bus.k_tile, 0);
    chk("reset stall", stall_cycles, 0);
    chk("reset result", host_result, 0);

    for (int a = 0; a < DEPTH; a++)
      for (int s = 0; s < 3; s++) hwrite(s, a, DW'($urandom));

    // 1: four beats, always ready, result after a short delay
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < 3; s++) hwrite(s, i, DW'(i + 1));
    rdy_mode = 0; resp_delay = 2; resp_data = 16'h0064; noise = 0;
    beat_q.delete(); start_cnt = 0; done_cnt = 0;
    start_run(4, acc);
    wait_idle(200, "t1");
    chk("t1 start cycle", start_cyc, acc);
    chk("t1 beat count", beat_q.size(), 4);
    if (beat_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("t1 beat q", beat_q[i], DW'(i + 1));
    chk("t1 last beat cycle", last_hs_cyc, acc + 4);
    chk("t1 result", host_result, 16'h0064);
    chk("t1 result_valid", host_result_valid, 1);
    chk("t1 done count", done_cnt, 1);
    chk("t1 start count", start_cnt, 1);
    chk("t1 stalls", stall_cycles, 0);
    chk("t1 err", host_err, 0);

    // 2: eight beats, ready low every other cycle starting low
    for (int i = 0; i < 8; i++) begin
      wq[i] = DW'($urandom);
      hwrite(0, i, wq[i]);
    end
    rdy_mode = 1; vcnt = 0; resp_delay = 1; resp_data = 16'h0A0B;
    beat_q.delete();
    start_run(8, acc);
    wait_idle(200, "t2");
    chk("t2 stalls", stall_cycles, 8);
    chk("t2 k_tile", core_bus.k_tile, 8);
    chk("t2 beat count", beat_q.size(), 8);
    if (beat_q.size() == 8)
      for (int i = 0; i < 8; i++) chk("t2 beat order", beat_q[i], wq[i]);

    // 3: zero length means a full buffer; oversize length is rejected
    rdy_mode = 2; resp_delay = 0;
    beat_q.delete();
    start_run(0, acc);
    tick();
    chk("t3 k_tile full", core_bus.k_tile, 64);
    wait_idle(2000, "t3");
    chk("t3 beat count", beat_q.size(), 64);
    sc = start_cnt; done_cnt = 0;
    start_run(65, acc);
    tick(3);
    chk("t3 reject err", host_err, 1);
    chk("t3 reject busy", host_busy, 0);
    chk("t3 reject no start", start_cnt, sc);
    chk("t3 reject no done", done_cnt, 0);

    // 4: core never answers -> timeout
    rdy_mode = 0; resp_delay = -1; done_cnt = 0;
    start_run(3, acc);
    wait_idle(200, "t4");
    chk("t4 timeout distance", done_cyc - last_hs_cyc, 17);
    chk("t4 err", host_err, 1);
    chk("t4 result_valid", host_result_valid, 0);
    chk("t4 done count", done_cnt, 1);

    // 5: writes and starts while busy are dropped
    hwrite(0, 0, 16'h1234);
    rdy_mode = 1; vcnt = 0; resp_delay = 4; start_cnt = 0;
    start_run(4, acc);
    tick();
    host_wr_en = 1'b1; host_wr_sel = 2'd0; host_wr_addr = '0; host_wr_data = 16'hBEEF;
    host_start = 1'b1; host_len = 16'd2;
    tick();
    host_wr_en = 1'b0; host_start = 1'b0;
    wait_idle(200, "t5a");
    chk("t5 one start per run", start_cnt, 1);
    rdy_mode = 0; beat_q.delete();
    start_run(1, acc);
    wait_idle(200, "t5b");
    chk("t5 original q0", (beat_q.size() > 0) ? beat_q[0] : 16'hxxxx, 16'h1234);
    chk("t5 start count", start_cnt, 2);

    // 6: reset in the middle of a run, then a clean short run
    rdy_mode = 1; vcnt = 0; resp_delay = 2; beat_q.delete();
    start_run(8, acc);
    ln = 0;
    while (beat_q.size() < 3 && ln < 100) begin tick(); ln++; end
    chk("t6 reached beat 3", beat_q.size() >= 3, 1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst busy", host_busy, 0);
    chk("t6 rst in_valid", core_bus.in_valid, 0);
    chk("t6 rst q", core_bus.q, 0);
    chk("t6 rst k_tile", core_bus.k_tile, 0);
    chk("t6 rst stall", stall_cycles, 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 3; s++) hwrite(s, i, DW'($urandom));
    rdy_mode = 0; resp_delay = 1; resp_data = 16'h5A5A;
    start_run(2, acc);
    wait_idle(200, "t6");
    chk("t6 result", host_result, 16'h5A5A);
    chk("t6 result_valid", host_result_valid, 1);
    chk("t6 err", host_err, 0);

    // 7: randomized runs with a write landing on the start cycle
    for (int r = 0; r < 10; r++) begin
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) hwrite($urandom_range(0, 3), $urandom_range(0, 15), DW'($urandom));
      rdy_mode = 2; noise = 1;
      resp_delay = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      resp_data = DW'($urandom);
      host_wr_en = 1'b1; host_wr_sel = 2'($urandom_range(0, 2)); host_wr_addr = '0;
      host_wr_data = DW'($urandom);
      ln = $urandom_range(0, 12);
      start_run(ln, acc);
      host_wr_data = DW'($urandom);
      tick();
      host_wr_en = 1'b0;
      wait_idle(2000, "t7");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
